// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter in front of one memory port (Mout_*/DataRdy protocol).
// One transaction in flight; a watchdog aborts transactions the memory never completes.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_oe_ram,
  input  logic              m0_we_ram,
  input  logic [ADDR_W-1:0] m0_addr_ram,
  input  logic [DATA_W-1:0] m0_Wdata_ram,
  input  logic [SIZE_W-1:0] m0_data_ram_size,
  output logic [DATA_W-1:0] m0_Rdata_ram,
  output logic              m0_DataRdy,
  input  logic              m1_oe_ram,
  input  logic              m1_we_ram,
  input  logic [ADDR_W-1:0] m1_addr_ram,
  input  logic [DATA_W-1:0] m1_Wdata_ram,
  input  logic [SIZE_W-1:0] m1_data_ram_size,
  output logic [DATA_W-1:0] m1_Rdata_ram,
  output logic              m1_DataRdy,
  output logic              mem_oe_ram,
  output logic              mem_we_ram,
  output logic [ADDR_W-1:0] mem_addr_ram,
  output logic [DATA_W-1:0] mem_Wdata_ram,
  output logic [SIZE_W-1:0] mem_data_ram_size,
  input  logic [DATA_W-1:0] mem_Rdata_ram,
  input  logic              mem_DataRdy,
  output logic [1:0]        grant,
  output logic              err_timeout,
  output logic              err_proto
);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [1:0]             m_oe, m_we, req, illegal, m_rdy;
  logic [1:0][ADDR_W-1:0] m_addr;
  logic [1:0][DATA_W-1:0] m_wdata, m_rdata;
  logic [1:0][SIZE_W-1:0] m_size;

  assign m_oe    = {m1_oe_ram, m0_oe_ram};
  assign m_we    = {m1_we_ram, m0_we_ram};
  assign m_addr  = {m1_addr_ram, m0_addr_ram};
  assign m_wdata = {m1_Wdata_ram, m0_Wdata_ram};
  assign m_size  = {m1_data_ram_size, m0_data_ram_size};
  assign req     = m_oe ^ m_we;
  assign illegal = m_oe & m_we;

  state_t          state, state_nx;
  logic [1:0]      grant_q, grant_nx;
  logic [1:0]      op_q, op_nx;     // {oe,we} captured at grant, to catch type changes
  logic            rr_ptr, rr_nx;
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            tmo_nx, proto_nx, err_timeout_q, err_proto_q;
  logic            busy, gsel, sel, op_bad, wd_last;
  logic [1:0]      cur_op;

  assign busy    = (state == BUSY);
  assign gsel    = grant_q[1];
  assign cur_op  = {m_oe[gsel], m_we[gsel]};
  assign op_bad  = (cur_op != op_q);
  assign wd_last = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    op_nx    = op_q;
    rr_nx    = rr_ptr;
    wd_nx    = wd_cnt;
    tmo_nx   = 1'b0;
    proto_nx = |illegal;
    sel      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          sel      = (req == 2'b11) ? rr_ptr : req[1];
          grant_nx = sel ? 2'b10 : 2'b01;
          op_nx    = {m_oe[sel], m_we[sel]};
          wd_nx    = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // completion beats protocol error beats watchdog
        if (mem_DataRdy || op_bad || wd_last) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
          rr_nx    = ~gsel;
          proto_nx = (|illegal) | (!mem_DataRdy && op_bad);
          tmo_nx   = !mem_DataRdy && !op_bad;
        end else begin
          wd_nx = wd_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant_q       <= 2'b00;
      op_q          <= 2'b00;
      rr_ptr        <= 1'b0;
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state         <= state_nx;
      grant_q       <= grant_nx;
      op_q          <= op_nx;
      rr_ptr        <= rr_nx;
      wd_cnt        <= wd_nx;
      err_timeout_q <= tmo_nx;
      err_proto_q   <= proto_nx;
    end
  end

  // downstream is a pure mux on the registered grant; zero while idle
  assign mem_oe_ram        = busy & m_oe[gsel];
  assign mem_we_ram        = busy & m_we[gsel];
  assign mem_addr_ram      = busy ? m_addr[gsel]  : '0;
  assign mem_Wdata_ram     = busy ? m_wdata[gsel] : '0;
  assign mem_data_ram_size = busy ? m_size[gsel]  : '0;

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign m_rdy[i]   = busy & (gsel == 1'(i)) & mem_DataRdy;
    assign m_rdata[i] = (busy && gsel == 1'(i)) ? mem_Rdata_ram : '0;
  end

  assign m0_DataRdy   = m_rdy[0];
  assign m1_DataRdy   = m_rdy[1];
  assign m0_Rdata_ram = m_rdata[0];
  assign m1_Rdata_ram = m_rdata[1];
  assign grant        = grant_q;
  assign err_timeout  = err_timeout_q;
  assign err_proto    = err_proto_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: master drivers, a fixed-latency memory model and a
// per-master scoreboard of expected completions.
module tb_mem_port_arbiter;
  localparam int AW = 9, DW = 8, SW = 4, TMO = 8, DLY = 2;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]         m_oe = '0, m_we = '0;
  logic [1:0][AW-1:0] m_addr = '0;
  logic [1:0][DW-1:0] m_wd = '0;
  logic [SW-1:0]      size = 4'd8;
  logic [DW-1:0]      m0_rd, m1_rd, mem_wd, mem_rdata;
  logic               m0_rdy, m1_rdy, mem_oe, mem_we, mem_rdy = 1'b0;
  logic [AW-1:0]      mem_addr;
  logic [SW-1:0]      mem_size;
  logic [1:0]         grant;
  logic               err_timeout, err_proto;

  assign mem_rdata = 8'(mem_addr) ^ 8'h5A;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .m0_oe_ram(m_oe[0]), .m0_we_ram(m_we[0]), .m0_addr_ram(m_addr[0]),
    .m0_Wdata_ram(m_wd[0]), .m0_data_ram_size(size),
    .m0_Rdata_ram(m0_rd), .m0_DataRdy(m0_rdy),
    .m1_oe_ram(m_oe[1]), .m1_we_ram(m_we[1]), .m1_addr_ram(m_addr[1]),
    .m1_Wdata_ram(m_wd[1]), .m1_data_ram_size(size),
    .m1_Rdata_ram(m1_rd), .m1_DataRdy(m1_rdy),
    .mem_oe_ram(mem_oe), .mem_we_ram(mem_we), .mem_addr_ram(mem_addr),
    .mem_Wdata_ram(mem_wd), .mem_data_ram_size(mem_size),
    .mem_Rdata_ram(mem_rdata), .mem_DataRdy(mem_rdy),
    .grant(grant), .err_timeout(err_timeout), .err_proto(err_proto)
  );

  typedef struct packed {logic rd; logic [AW-1:0] addr; logic [DW-1:0] wd;} req_t;
  req_t rq0[$], rq1[$], ex0[$], ex1[$];
  int   glog[$];
  int   n_vec = 0, n_err = 0, mcnt = 0;
  logic mem_en = 1'b1, force_rdy = 1'b0, prev_rdy = 1'b0;
  logic [1:0] done = '0, prev_grant = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int m, input req_t r);
    m_oe[m] = r.rd; m_we[m] = ~r.rd; m_addr[m] = r.addr; m_wd[m] = r.wd;
  endtask

  // drive phase: masters release after completion, fetch next request; memory model
  task automatic tick();
    req_t r;
    @(posedge clock); #1;
    for (int m = 0; m < 2; m++)
      if (done[m]) begin m_oe[m] = 1'b0; m_we[m] = 1'b0; done[m] = 1'b0; end
    if (!m_oe[0] && !m_we[0] && rq0.size() > 0) begin r = rq0.pop_front(); load(0, r); ex0.push_back(r); end
    if (!m_oe[1] && !m_we[1] && rq1.size() > 0) begin r = rq1.pop_front(); load(1, r); ex1.push_back(r); end
    mcnt    = (grant != 2'b00) ? mcnt + 1 : 0;
    mem_rdy = force_rdy | (mem_en && grant != 2'b00 && mcnt == DLY + 1);
  endtask

  // sample phase: grant log, turnaround, scoreboard pops on completions
  task automatic mon();
    req_t e;
    if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant[1] ? 1 : 0);
    if (prev_rdy) chk("turnaround_grant", grant, 0);
    if (m0_rdy) begin
      if (ex0.size() == 0) chk("m0_rdy_unexp", m0_rdy, 0);
      else begin
        e = ex0.pop_front();
        chk("m0_grant", grant, 2'b01);
        chk("m0_addr", mem_addr, e.addr);
        chk("m0_size", mem_size, 8);
        chk("m1_rdy_quiet", m1_rdy, 0);
        chk("m1_rdata_quiet", m1_rd, 0);
        if (e.rd) chk("m0_rdata", m0_rd, e.addr[7:0] ^ 8'h5A);
        else      chk("m0_wdata", mem_wd, e.wd);
        done[0] = 1'b1;
      end
    end
    if (m1_rdy) begin
      if (ex1.size() == 0) chk("m1_rdy_unexp", m1_rdy, 0);
      else begin
        e = ex1.pop_front();
        chk("m1_grant", grant, 2'b10);
        chk("m1_addr", mem_addr, e.addr);
        chk("m0_rdy_quiet", m0_rdy, 0);
        chk("m0_rdata_quiet", m0_rd, 0);
        if (e.rd) chk("m1_rdata", m1_rd, e.addr[7:0] ^ 8'h5A);
        else      chk("m1_wdata", mem_wd, e.wd);
        done[1] = 1'b1;
      end
    end
    prev_rdy   = m0_rdy | m1_rdy;
    prev_grant = grant;
  endtask

  task automatic cyc();
    tick();
    @(negedge clock);
    mon();
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (k < max && !(rq0.size() == 0 && rq1.size() == 0 && ex0.size() == 0 && ex1.size() == 0
                        && m_oe == 2'b00 && m_we == 2'b00 && grant == 2'b00)) begin
      cyc(); k++;
    end
    chk("drain_bound", k < max, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_mem_oe", mem_oe, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err_tmo", err_timeout, 0);
    chk("rst_err_proto", err_proto, 0);
    chk("rst_rdy", {m1_rdy, m0_rdy}, 0);
    chk("rst_rdata", {m1_rd, m0_rd}, 0);
    reset = 1'b0;

    // both masters hammer writes from reset: strict alternation starting at m0
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      rq0.push_back('{1'b0, 9'(16 + i), 8'(8'h10 + i)});
      rq1.push_back('{1'b0, 9'(32 + i), 8'(8'h20 + i)});
    end
    drain(80);
    chk("b2b_count", glog.size(), 6);
    for (int i = 0; i < glog.size(); i++) chk("b2b_order", glog[i], i % 2);

    // single read, memory answers two cycles after mem_oe
    rq0.push_back('{1'b1, 9'h0FF, 8'h00});
    cyc(); chk("rd_pre_grant", grant, 0);
    cyc(); chk("rd_grant", grant, 2'b01); chk("rd_mem_oe", mem_oe, 1); chk("rd_mem_addr", mem_addr, 9'h0FF);
    cyc(); chk("rd_wait", m0_rdy, 0);
    cyc(); chk("rd_rdy", m0_rdy, 1); chk("rd_data", m0_rd, 8'hA5); chk("rd_m1_rdy", m1_rdy, 0);
    cyc(); chk("rd_release", grant, 0); chk("rd_mem_idle", mem_oe, 0);

    // stray DataRdy while idle goes nowhere
    force_rdy = 1'b1;
    cyc(); chk("idle_rdy_m0", m0_rdy, 0); chk("idle_rdy_m1", m1_rdy, 0); chk("idle_grant", grant, 0);
    force_rdy = 1'b0;
    cyc();

    // m1 holds oe&we: never granted, err_proto every cycle, m0 unaffected
    glog.delete();
    m_oe[1] = 1'b1; m_we[1] = 1'b1;
    rq0.push_back('{1'b1, 9'h040, 8'h00});
    rq0.push_back('{1'b1, 9'h041, 8'h00});
    for (int k = 0; k < 12; k++) begin
      cyc(); chk("ill_proto", err_proto, 1); chk("ill_no_m1", grant[1], 0);
    end
    m_oe[1] = 1'b0; m_we[1] = 1'b0;
    cyc(); chk("ill_clear", err_proto, 0);
    drain(30);
    chk("ill_m0_served", glog.size(), 2);

    // m0 drops oe inside BUSY; pending m1 takes over after one idle cycle
    m_oe[0] = 1'b1; m_addr[0] = 9'h003;
    cyc(); chk("drop_grant", grant, 2'b01);
    m_oe[0] = 1'b0;
    m_oe[1] = 1'b1; m_addr[1] = 9'h005;
    ex1.push_back('{1'b1, 9'h005, 8'h00});
    cyc(); chk("drop_proto", err_proto, 1); chk("drop_idle", grant, 0);
    cyc(); chk("drop_m1_grant", grant, 2'b10); chk("drop_pulse", err_proto, 0);
    drain(20);

    // reset in the middle of an m1 write; afterwards m0 is preferred again
    rq0.push_back('{1'b1, 9'h010, 8'h00});
    drain(20);
    m_we[1] = 1'b1; m_addr[1] = 9'h020; m_wd[1] = 8'h3C;
    cyc(); chk("rst_pre_grant", grant, 2'b10); chk("rst_pre_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_grant", grant, 0);
    chk("rst_async_we", mem_we, 0);
    chk("rst_async_addr", mem_addr, 0);
    chk("rst_async_rdy", m1_rdy, 0);
    m_we[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    glog.delete();
    rq0.push_back('{1'b1, 9'h011, 8'h00});
    rq1.push_back('{1'b1, 9'h021, 8'h00});
    drain(30);
    chk("rst_count", glog.size(), 2);
    if (glog.size() > 0) chk("rst_rr_first", glog[0], 0);

    // memory goes silent: watchdog fires TIMEOUT cycles after the grant
    mem_en = 1'b0;
    m_oe[0] = 1'b1; m_addr[0] = 9'h077;
    cyc(); chk("tmo_grant", grant, 2'b01);
    for (int k = 1; k < TMO; k++) begin
      cyc(); chk("tmo_no_rdy", m0_rdy, 0); chk("tmo_quiet", err_timeout, 0);
    end
    chk("tmo_hold", grant, 2'b01);
    cyc(); chk("tmo_pulse", err_timeout, 1); chk("tmo_release", grant, 0); chk("tmo_no_rdy_end", m0_rdy, 0);
    m_oe[0] = 1'b0;
    cyc(); chk("tmo_one_shot", err_timeout, 0); chk("tmo_idle", grant, 0);
    mem_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
